obstacle_scheduler: RTL

Controller that sequences the obstacle stream of the side-scroller. It owns a fixed pool of obstacle slots and decides when each slot is spawned at the right screen edge. It advances all live slots on every game tick, retires slots that leave the screen and counts them. It sits between the level controller (run/clear) and the VGA renderer (slot positions/kinds), replacing a single free-running obstacle position counter with a scheduled, multi-obstacle pool.

---
 rtl/obstacle_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Schedules the side-scroller obstacle stream. It keeps a fixed pool of
// obstacle slots, spawns slots at the right screen edge after a
// pseudo-random scroll gap, moves every live slot left on each game tick,
// and retires and counts the slots that leave the screen.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   tick         one-cycle game-tick pulse, synchronous to clk
//   run          1 = playing, 0 = scheduler and slots frozen
//   clear        synchronous pool flush (level restart / death)
//   obj_active   per-slot live flag
//   obj_x        per-slot x position, slot i at [10i+9:10i]
//   obj_kind     per-slot type: 0 ground block, 1 falling square
//   spawn_pulse  one-cycle pulse when a slot is spawned
//   passed_count obstacles retired since the last clear, saturating at 255
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | run=0, nothing moves; run=1 goes to ST_GAP
// ST_GAP   | scrolling; gap_cnt grows by SPEED per tick up to gap_target
// ST_SPAWN | one cycle; write the lowest free slot, or go to ST_STALL
// ST_STALL | pool full; wait for a free slot, then go to ST_SPAWN

module obstacle_scheduler #(
  parameter int          NUM_SLOTS = 4,
  parameter int          X_START   = 640,
  parameter int          SPEED     = 4,
  parameter int          MIN_GAP   = 96,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   run,
  input  logic                   clear,
  output logic [NUM_SLOTS-1:0]   obj_active,
  output logic [10*NUM_SLOTS-1:0] obj_x,
  output logic [NUM_SLOTS-1:0]   obj_kind,
  output logic                   spawn_pulse,
  output logic [7:0]             passed_count
);

  localparam int         IDX_W     = $clog2(NUM_SLOTS);
  localparam logic [9:0] X_START_W = 10'(X_START);
  localparam logic [9:0] SPEED_W   = 10'(SPEED);
  localparam logic [9:0] MIN_GAP_W = 10'(MIN_GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_SPAWN = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [9:0]        gap_cnt;
  logic [9:0]        gap_target;

  logic              advance;
  logic              free_any;
  logic [IDX_W-1:0]  free_idx;
  logic [9:0]        slot_x [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] retire;
  logic [3:0]        retire_cnt;
  logic [10:0]       gap_sum;
  logic [9:0]        gap_inc;
  logic [8:0]        pass_sum;
  logic [7:0]        pass_nxt;
  logic              do_spawn;
  logic              do_gap_inc;

  assign advance = tick & run;

  // Free-slot search uses the registered flags, so a slot retired on this
  // cycle's tick only becomes available from the next cycle.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!obj_active[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    retire     = '0;
    retire_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_x[i] = obj_x[10*i +: 10];
      if (advance && obj_active[i] && (slot_x[i] < SPEED_W)) begin
        retire[i]  = 1'b1;
        retire_cnt = retire_cnt + 4'd1;
      end
    end
  end

  assign gap_sum  = {1'b0, gap_cnt} + {1'b0, SPEED_W};
  assign gap_inc  = gap_sum[10] ? 10'h3FF : gap_sum[9:0];
  assign pass_sum = {1'b0, passed_count} + {5'b0, retire_cnt};
  assign pass_nxt = pass_sum[8] ? 8'hFF : pass_sum[7:0];

  always_comb begin
    state_nxt  = state;
    do_spawn   = 1'b0;
    do_gap_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          do_gap_inc = 1'b1;
          if (gap_inc >= gap_target) state_nxt = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (free_any) begin
          do_spawn  = 1'b1;
          state_nxt = ST_GAP;
        end else begin
          state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!run) state_nxt = ST_IDLE;
        else if (free_any) state_nxt = ST_SPAWN;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = run ? ST_GAP : ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The LFSR is never flushed by clear so consecutive levels differ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obj_active   <= '0;
      obj_x        <= '0;
      obj_kind     <= '0;
      spawn_pulse  <= 1'b0;
      passed_count <= 8'd0;
      gap_cnt      <= 10'd0;
      gap_target   <= MIN_GAP_W;
    end else if (clear) begin
      obj_active   <= '0;
      obj_x        <= '0;
      obj_kind     <= '0;
      spawn_pulse  <= 1'b0;
      passed_count <= 8'd0;
      gap_cnt      <= 10'd0;
      gap_target   <= MIN_GAP_W;
    end else begin
      spawn_pulse  <= do_spawn;
      passed_count <= pass_nxt;
      if (do_gap_inc) gap_cnt <= gap_inc;
      if (do_spawn) begin
        gap_cnt    <= 10'd0;
        gap_target <= MIN_GAP_W + {4'b0, lfsr[6:1]};
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (do_spawn && (free_idx == IDX_W'(i))) begin
          obj_active[i]      <= 1'b1;
          obj_x[10*i +: 10]  <= X_START_W;
          obj_kind[i]        <= lfsr[0];
        end else if (retire[i]) begin
          obj_active[i]      <= 1'b0;
          obj_x[10*i +: 10]  <= 10'd0;
        end else if (advance && obj_active[i]) begin
          obj_x[10*i +: 10]  <= slot_x[i] - SPEED_W;
        end
      end
    end
  end

endmodule
